// File: rtl/memory_load_controller.sv
// memory_load_controller
// Multi-bank RAM front end. In IDLE every bank passes the core's controls
// straight through. On a load request, a valid/ready word stream is written
// into one bank from a programmable base address while the core is held.
// Optional feature macro: LOAD_CHECKSUM_EN. When it is defined, load_checksum
// sums the accepted words of the current load; otherwise it is tied to zero.
//
// Stream handshake: a word transfers on every rising clk edge where
// s_valid && s_ready. s_ready is high exactly while in LOAD, and s_data is
// written to the RAM in that same cycle.

module memory_load_controller #(
    parameter int NUM_BANKS      = 2,
    parameter int BANK_SEL_WIDTH = 1,
    parameter int ADDRESS_WIDTH  = 11,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load_start,
    input  logic [BANK_SEL_WIDTH-1:0]           load_bank,
    input  logic [ADDRESS_WIDTH-1:0]            load_base,
    input  logic [ADDRESS_WIDTH:0]              load_count,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [DATA_WIDTH-1:0]               s_data,
    input  logic [NUM_BANKS-1:0]                core_cen,
    input  logic [NUM_BANKS-1:0]                core_wen,
    input  logic [NUM_BANKS-1:0]                core_oen,
    input  logic [NUM_BANKS*ADDRESS_WIDTH-1:0]  core_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]     core_datain,
    output logic [NUM_BANKS-1:0]                mem_cen,
    output logic [NUM_BANKS-1:0]                mem_wen,
    output logic [NUM_BANKS-1:0]                mem_oen,
    output logic [NUM_BANKS*ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]     mem_datain,
    output logic                                core_hold,
    output logic                                load_busy,
    output logic                                load_done,
    output logic                                load_err,
    output logic [DATA_WIDTH-1:0]               load_checksum
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW:0] IDX_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [BANK_SEL_WIDTH-1:0] bank_q;
    logic [AW-1:0]             base_q;
    logic [AW:0]               count_q;
    logic [AW:0]               idx_q;

    logic bank_ok;
    logic start_ok;
    logic handshake;
    logic last_word;

    assign bank_ok   = int'(load_bank) < NUM_BANKS;
    assign start_ok  = (state == S_IDLE) && load_start && bank_ok;
    assign handshake = (state == S_LOAD) && s_valid;
    // idx counts words already written; the handshake writing word count-1 ends the load
    assign last_word = (idx_q + IDX_ONE) == count_q;

    // Main sequencer: state, latched load parameters and all registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bank_q    <= '0;
            base_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            core_hold <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    load_done <= 1'b0;
                    load_err  <= 1'b0;
                    core_hold <= 1'b0;
                    if (load_start) begin
                        if (bank_ok) begin
                            bank_q    <= load_bank;
                            base_q    <= load_base;
                            count_q   <= load_count;
                            idx_q     <= '0;
                            core_hold <= 1'b1;
                            if (load_count != '0) begin
                                state     <= S_LOAD;
                                load_busy <= 1'b1;
                                s_ready   <= 1'b1;
                            end else begin
                                // Empty load: go straight to the completion pulse
                                state     <= S_DONE;
                                load_done <= 1'b1;
                            end
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // New load requests are ignored until this transfer completes
                    if (handshake) begin
                        idx_q <= idx_q + IDX_ONE;
                        if (last_word) begin
                            state     <= S_DONE;
                            load_busy <= 1'b0;
                            s_ready   <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // core_hold stays up through DONE and drops on the following IDLE cycle
                    state     <= S_IDLE;
                    load_done <= 1'b0;
                    core_hold <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    core_hold <= 1'b0;
                    load_busy <= 1'b0;
                    load_done <= 1'b0;
                    s_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Bank mux: core pass-through in IDLE, loader write on the selected bank in LOAD
    always_comb begin
        mem_cen    = core_cen;
        mem_wen    = core_wen;
        mem_oen    = core_oen;
        mem_addr   = core_addr;
        mem_datain = core_datain;
        if (state != S_IDLE) begin
            // Core requests are dropped while the loader owns the banks
            mem_cen = '1;
            mem_wen = '1;
            mem_oen = '1;
            if (state == S_LOAD) begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (int'(bank_q) == i) begin
                        mem_cen[i]             = ~s_valid;
                        mem_wen[i]             = ~s_valid;
                        mem_addr[i*AW +: AW]   = base_q + idx_q[AW-1:0];
                        mem_datain[i*DW +: DW] = s_data;
                    end
                end
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    // Running sum of accepted words, cleared when a legal load is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_checksum <= '0;
        end else if (start_ok) begin
            load_checksum <= '0;
        end else if (handshake) begin
            load_checksum <= load_checksum + s_data;
        end
    end
`else
    assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_memory_load_controller.sv
// Testbench for memory_load_controller. Loader writes are pushed into an
// expected queue by the stimulus and checked by a monitor that watches the
// RAM ports whenever the core is held. Status timing is checked directly.

module tb_memory_load_controller;

    localparam int NB = 2;
    localparam int BW = 2;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int W  = BW + AW + DW + 2;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic [BW-1:0]     load_bank;
    logic [AW-1:0]     load_base;
    logic [AW:0]       load_count;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [NB-1:0]     core_cen;
    logic [NB-1:0]     core_wen;
    logic [NB-1:0]     core_oen;
    logic [NB*AW-1:0]  core_addr;
    logic [NB*DW-1:0]  core_datain;
    logic [NB-1:0]     mem_cen;
    logic [NB-1:0]     mem_wen;
    logic [NB-1:0]     mem_oen;
    logic [NB*AW-1:0]  mem_addr;
    logic [NB*DW-1:0]  mem_datain;
    logic              core_hold;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [DW-1:0]     load_checksum;

    logic [W-1:0] exp_q[$];
    int vectors;
    int errors;

    memory_load_controller #(
        .NUM_BANKS(NB), .BANK_SEL_WIDTH(BW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_bank(load_bank), .load_base(load_base),
        .load_count(load_count),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_cen(core_cen), .core_wen(core_wen), .core_oen(core_oen),
        .core_addr(core_addr), .core_datain(core_datain),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
        .mem_addr(mem_addr), .mem_datain(mem_datain),
        .core_hold(core_hold), .load_busy(load_busy), .load_done(load_done),
        .load_err(load_err), .load_checksum(load_checksum)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] ck(input logic [DW-1:0] v);
`ifdef LOAD_CHECKSUM_EN
        return v;
`else
        return '0 & v;
`endif
    endfunction

    function automatic logic [W-1:0] wr(input int bank, input logic [AW-1:0] addr,
                                        input logic [DW-1:0] data);
        logic [BW-1:0] b;
        b = BW'(bank);
        return {b, addr, data, 1'b0, 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_load(input int bank, input logic [AW-1:0] base, input logic [AW:0] count);
        load_start = 1'b1;
        load_bank  = BW'(bank);
        load_base  = base;
        load_count = count;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int bank, input logic [AW-1:0] addr);
        s_valid = 1'b1;
        s_data  = d;
        exp_q.push_back(wr(bank, addr, d));
        step();
        s_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        s_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic core_idle();
        core_cen    = '1;
        core_wen    = '1;
        core_oen    = '1;
        core_addr   = '0;
        core_datain = '0;
    endtask

    // Called right after the last word: expects DONE now and IDLE next cycle
    task automatic expect_done(input string tag, input logic [DW-1:0] sum);
        check({tag, "_done"},      64'(load_done), 64'd1);
        check({tag, "_hold_done"}, 64'(core_hold), 64'd1);
        check({tag, "_ready_done"},64'(s_ready),   64'd0);
        check({tag, "_busy_done"}, 64'(load_busy), 64'd0);
        check({tag, "_checksum"},  64'(load_checksum), 64'(ck(sum)));
        step();
        check({tag, "_done_clr"},  64'(load_done), 64'd0);
        check({tag, "_hold_clr"},  64'(core_hold), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    // While the core is held, any bank with cen low must match the next expected write
    always @(negedge clk) begin
        if (rst_n && core_hold) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_cen[i] == 1'b0) begin
                    logic [W-1:0] got;
                    logic [BW-1:0] b;
                    b = BW'(i);
                    got = {b, mem_addr[i*AW +: AW], mem_datain[i*DW +: DW], mem_wen[i], mem_oen[i]};
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(got), 64'd0);
                    end else begin
                        check("mem_write", 64'(got), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vectors    = 0;
        errors     = 0;
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_bank  = '0;
        load_base  = '0;
        load_count = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        core_idle();

        #12;
        check("rst_hold",     64'(core_hold), 64'd0);
        check("rst_busy",     64'(load_busy), 64'd0);
        check("rst_done",     64'(load_done), 64'd0);
        check("rst_err",      64'(load_err),  64'd0);
        check("rst_ready",    64'(s_ready),   64'd0);
        check("rst_checksum", 64'(load_checksum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Pass-through: bank 1 write from the core appears the same cycle
        core_addr[AW +: AW] = 11'h005;
        core_cen = 2'b01;
        core_wen = 2'b01;
        #1;
        check("pt_addr1", 64'(mem_addr[AW +: AW]), 64'h005);
        check("pt_wen1",  64'(mem_wen[1]), 64'd0);
        check("pt_cen1",  64'(mem_cen[1]), 64'd0);
        check("pt_wen0",  64'(mem_wen[0]), 64'd1);
        check("pt_hold",  64'(core_hold), 64'd0);
        core_idle();
        step();

        // Basic load: bank 0, base 0, four back-to-back words
        start_load(0, 11'h000, 12'd4);
        check("basic_hold",  64'(core_hold), 64'd1);
        check("basic_busy",  64'(load_busy), 64'd1);
        check("basic_ready", 64'(s_ready),   64'd1);
        send_word(32'd1, 0, 11'h000);
        send_word(32'd2, 0, 11'h001);
        send_word(32'd3, 0, 11'h002);
        send_word(32'd4, 0, 11'h003);
        expect_done("basic", 32'd10);

        // Illegal bank: error pulse only, checksum untouched
        start_load(2, 11'h010, 12'd3);
        check("err_pulse", 64'(load_err),  64'd1);
        check("err_hold",  64'(core_hold), 64'd0);
        check("err_busy",  64'(load_busy), 64'd0);
        check("err_checksum", 64'(load_checksum), 64'(ck(32'd10)));
        step();
        check("err_clr",   64'(load_err),  64'd0);

        // Zero count: done one cycle after the request, no write
        start_load(1, 11'h020, 12'd0);
        expect_done("zero", 32'd0);

        // Gapped stream with address wrap on bank 1; core requests are dropped
        start_load(1, 11'h7FE, 12'd3);
        core_cen = 2'b00;
        core_wen = 2'b00;
        core_addr = {11'h111, 11'h222};
        send_word(32'h1111_1111, 1, 11'h7FE);
        gap(2);
        send_word(32'h2222_2222, 1, 11'h7FF);
        gap(2);
        send_word(32'hF000_0000, 1, 11'h000);
        expect_done("wrap", 32'h2333_3333);
        core_idle();

        // Reset in the middle of a load
        start_load(0, 11'h010, 12'd8);
        send_word(32'hA, 0, 11'h010);
        send_word(32'hB, 0, 11'h011);
        send_word(32'hC, 0, 11'h012);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_hold",  64'(core_hold), 64'd0);
        check("mid_rst_busy",  64'(load_busy), 64'd0);
        check("mid_rst_ready", 64'(s_ready),   64'd0);
        check("mid_rst_done",  64'(load_done), 64'd0);
        check("mid_rst_checksum", 64'(load_checksum), 64'd0);
        check("mid_rst_passthru", 64'(mem_cen), 64'(core_cen));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        core_addr[0 +: AW] = 11'h033;
        core_cen = 2'b10;
        #1;
        check("post_rst_addr0", 64'(mem_addr[0 +: AW]), 64'h033);
        check("post_rst_cen",   64'(mem_cen), 64'h2);
        core_idle();
        step();
        start_load(1, 11'h020, 12'd2);
        send_word(32'h5, 1, 11'h020);
        send_word(32'h6, 1, 11'h021);
        expect_done("post_rst", 32'hB);

        // Ignored restart during LOAD
        start_load(0, 11'h100, 12'd3);
        load_start = 1'b1;
        load_bank  = 2'd1;
        load_base  = 11'h200;
        load_count = 12'd5;
        send_word(32'd5, 0, 11'h100);
        load_start = 1'b0;
        gap(1);
        send_word(32'd6, 0, 11'h101);
        send_word(32'd7, 0, 11'h102);
        expect_done("restart", 32'd18);
        check("restart_ck_hold", 64'(load_checksum), 64'(ck(32'd18)));

        step();
        step();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
